// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter:
// requester count, select width, FSM encoding and the cyclic pointer increment.
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] ptr_inc(input logic [SEL_W-1:0] p);
    return p + SEL_W'(1);
  endfunction

endpackage

// File: rtl/mux_4x1_beh.sv
// Behavioural 4:1 single-bit line multiplexer shared by the arbiter.
module mux_4x1_beh (
  input  logic [3:0] i_din,
  input  logic [1:0] i_sel,
  output logic       o_y
);

  always_comb begin
    case (i_sel)
      2'd0:    o_y = i_din[0];
      2'd1:    o_y = i_din[1];
      2'd2:    o_y = i_din[2];
      default: o_y = i_din[3];
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set req bit at or after ptr, searching cyclically.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

  logic [NUM_REQ-1:0] w_rot;
  logic [SEL_W-1:0]   w_off;

  // w_rot[k] is the request k positions after ptr, so bit 0 has top priority
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    localparam logic [SEL_W-1:0] OFF = SEL_W'(gi);
    logic [SEL_W-1:0] w_src;
    assign w_src     = ptr + OFF;
    assign w_rot[gi] = req[w_src];
  end

  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = SEL_W'(k);
    end
  end

  assign idx = ptr + w_off;
  assign any = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin burst scheduler in front of a 4:1 mux with a valid/ready output.
// Optional per-requester burst lock is enabled by defining MUX4_ARB_LOCK_EN.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] in_data,
`ifdef MUX4_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       lock,
`endif
  output logic [NUM_REQ-1:0]       ack,
  output logic [SEL_W-1:0]         select,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data
);

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [SEL_W-1:0] r_select;
  logic [SEL_W-1:0] w_select_next;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_ptr_next;
  logic [3:0]       r_beat_cnt;
  logic [3:0]       w_beat_cnt_next;

  logic [SEL_W-1:0] w_pick_ptr;
  logic [SEL_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic             w_xfer;
  logic             w_at_limit;
  logic             w_burst_end;
  logic             w_release;

  assign w_xfer     = out_valid && out_ready;
  assign w_at_limit = (r_beat_cnt >= BURST_LAST);

`ifdef MUX4_ARB_LOCK_EN
  assign w_burst_end = w_xfer && w_at_limit && !lock[r_select];
`else
  assign w_burst_end = w_xfer && w_at_limit;
`endif

  assign w_release = (r_state == GRANT) && (!req[r_select] || w_burst_end);

  // On release the search starts just past the current grant, giving it lowest priority
  assign w_pick_ptr = (r_state == GRANT) ? ptr_inc(r_select) : r_ptr;

  rr_pick4 u_pick (
    .req (req),
    .ptr (w_pick_ptr),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_select   <= '0;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_select   <= w_select_next;
      r_ptr      <= w_ptr_next;
      r_beat_cnt <= w_beat_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_select_next   = r_select;
    w_ptr_next      = r_ptr;
    w_beat_cnt_next = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_next    = GRANT;
          w_select_next   = w_pick_idx;
          w_beat_cnt_next = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_ptr_next = ptr_inc(r_select);
          if (w_pick_any) begin
            w_select_next   = w_pick_idx;
            w_beat_cnt_next = '0;
          end else begin
            w_state_next = IDLE;
          end
        end else if (w_xfer && !w_at_limit) begin
          // Saturation only matters while locked; otherwise the limit releases
          w_beat_cnt_next = r_beat_cnt + 4'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    ack       = '0;
    if (r_state == GRANT) begin
      out_valid     = req[r_select];
      ack[r_select] = req[r_select] && out_ready;
    end
  end

  assign select = r_select;

  if (WIDTH == 1) begin : g_line_mux
    mux_4x1_beh u_mux (
      .i_din (in_data),
      .i_sel (r_select),
      .o_y   (out_data)
    );
  end else begin : g_wide_mux
    assign out_data = in_data[r_select*WIDTH +: WIDTH];
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed scenarios plus randomized traffic
// checked against a grant/beat-count reference model.
module tb_mux4_rr_arbiter;

  localparam int W  = 1;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [3:0]     req = '0;
  logic [4*W-1:0] in_data = '0;
  logic           out_ready = 1'b0;
  logic [3:0]     ack;
  logic [1:0]     select;
  logic           out_valid;
  logic [W-1:0]   out_data;
`ifdef MUX4_ARB_LOCK_EN
  logic [3:0]     lock = '0;
`endif

  typedef struct {
    logic         valid;
    logic [3:0]   ack;
    logic [1:0]   sel;
    logic [W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: who owns the mux, how many beats it has had, where the search starts
  int m_owner = -1;
  int m_beats = 0;
  int m_ptr   = 0;
  int m_sel   = 0;

  mux4_rr_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_data   (in_data),
`ifdef MUX4_ARB_LOCK_EN
    .lock      (lock),
`endif
    .ack       (ack),
    .select    (select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, expv, $time);
  endtask

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.valid = (m_owner >= 0) && req[m_owner];
    e.ack   = (e.valid && out_ready) ? 4'(1 << m_owner) : 4'b0000;
    e.sel   = 2'(m_sel);
    e.data  = in_data[m_sel*W +: W];
    return e;
  endfunction

  task automatic model_arbitrate();
    int n;
    n = pick(req, m_ptr);
    if (n >= 0) begin
      m_owner = n;
      m_sel   = n;
      m_beats = 0;
    end else begin
      m_owner = -1;
    end
  endtask

  task automatic model_step();
    bit rel;
    bit locked;
    if (m_owner < 0) begin
      model_arbitrate();
    end else begin
      rel = 1'b0;
`ifdef MUX4_ARB_LOCK_EN
      locked = lock[m_owner];
`else
      locked = 1'b0;
`endif
      if (!req[m_owner]) begin
        rel = 1'b1;
      end else if (out_ready) begin
        m_beats++;
        if (m_beats >= MB && !locked) rel = 1'b1;
      end
      if (rel) begin
        m_ptr = (m_owner + 1) % 4;
        model_arbitrate();
      end
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_ptr   = 0;
    m_sel   = 0;
  endtask

  task automatic cyc(input logic [3:0] r, input logic rdy, input logic [4*W-1:0] d);
    @(posedge clk);
    #1;
    req       = r;
    out_ready = rdy;
    in_data   = d;
    exp_q.push_back(model_out());
    model_step();
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("valid",  32'(out_valid), 32'(e.valid));
        check("ack",    32'(ack),       32'(e.ack));
        check("select", 32'(select),    32'(e.sel));
        check("data",   32'(out_data),  32'(e.data));
        $display("cyc t=%0t req=%b rdy=%b sel=%0d valid=%b ack=%b data=%0h",
                 $time, req, out_ready, select, out_valid, ack, out_data);
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic       rdy;
    in_data = 4'b0001;
    #2;
    check("rst_valid",  32'(out_valid), 32'd0);
    check("rst_ack",    32'(ack),       32'd0);
    check("rst_select", 32'(select),    32'd0);
    check("rst_data",   32'(out_data),  32'(in_data[W-1:0]));
    #5 rst_n = 1'b1;
    model_reset();

    // Single requester: 4-beat bursts re-granted back-to-back
    repeat (10) cyc(4'b0100, 1'b1, 4'($urandom));
    repeat (2)  cyc(4'b0000, 1'b1, 4'($urandom));

    // Fairness with all requesting
    repeat (20) cyc(4'b1111, 1'b1, 4'($urandom));
    repeat (2)  cyc(4'b0000, 1'b1, 4'($urandom));

    // Backpressure on requester 1
    cyc(4'b0010, 1'b1, 4'($urandom));
    repeat (5) cyc(4'b0010, 1'b0, 4'($urandom));
    repeat (6) cyc(4'b0010, 1'b1, 4'($urandom));
    cyc(4'b0000, 1'b1, 4'($urandom));

    // Withdrawal while another requester waits
    repeat (2) cyc(4'b0011, 1'b1, 4'($urandom));
    repeat (3) cyc(4'b0010, 1'b1, 4'($urandom));
    cyc(4'b0000, 1'b1, 4'($urandom));

    // Data path on requester 3
    repeat (3) cyc(4'b1000, 1'b1, 4'b1000);
    repeat (2) cyc(4'b1000, 1'b1, 4'b0111);
    cyc(4'b0000, 1'b1, 4'($urandom));

    // Asynchronous reset between clock edges mid-burst
    repeat (7) cyc(4'b1111, 1'b1, 4'($urandom));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid",  32'(out_valid), 32'd0);
    check("arst_ack",    32'(ack),       32'd0);
    check("arst_select", 32'(select),    32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    model_step();
    repeat (6) cyc(4'b1111, 1'b1, 4'($urandom));

`ifdef MUX4_ARB_LOCK_EN
    // Locked requester 2 keeps the grant well past the burst limit
    repeat (2) cyc(4'b0000, 1'b1, 4'($urandom));
    lock = 4'b0100;
    repeat (12) cyc(4'b0110, 1'b1, 4'($urandom));
    lock = 4'b0000;
    repeat (6) cyc(4'b0110, 1'b1, 4'($urandom));
`endif

    // Randomized traffic with sticky requests
    r = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      rdy = ($urandom_range(0, 3) != 0);
`ifdef MUX4_ARB_LOCK_EN
      if ($urandom_range(0, 15) == 0) lock = 4'($urandom);
`endif
      cyc(r, rdy, 4'($urandom));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
